// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file write-back path.
// Holds register-file geometry, requester indices and a one-hot helper.
package regfile_pkg;

   localparam int XLEN   = 64;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;

   localparam int WB_ALU = 0;
   localparam int WB_LSU = 1;
   localparam int WB_MDU = 2;
   localparam int NREQ   = 3;

   // Decode a register index into a one-hot register mask.
   function automatic logic [NREGS-1:0] reg_onehot(
      input logic [REG_AW-1:0] a
   );
      logic [NREGS-1:0] m;
      m    = '0;
      m[a] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
// The scan starts at the pointer; after a grant the pointer moves past the winner.
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_nxt;
   logic          w_found;

   // Rotated priority scan: first valid requester at or after the pointer.
   always_comb begin
      gnt     = '0;
      w_idx   = r_ptr;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = int'(r_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!w_found && req[j]) begin
            w_found = 1'b1;
            gnt[j]  = 1'b1;
            w_idx   = PW'(j);
         end
      end
      if (rst) gnt = '0;
   end

   // Pointer for the next cycle: one past the winner, wrapping at NREQ.
   always_comb begin
      w_nxt = '0;
      if (int'(w_idx) != NREQ - 1) w_nxt = w_idx + 1'b1;
   end

   // Pointer register; it only moves on a completed handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (advance && w_found) begin
         r_ptr <= w_nxt;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the 32x64 integer regfile: round-robin write-back
// arbitration, registered write, and a busy scoreboard for hazard stalls.
module regfile_wb_arbiter #(
   parameter int XLEN = regfile_pkg::XLEN,
   parameter int NREQ = regfile_pkg::NREQ
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [5*NREQ-1:0]    req_addr,
   input  logic [XLEN*NREQ-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rf_wen,
   output logic [4:0]           rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   input  logic                 sb_set,
   input  logic [4:0]           sb_set_addr,
   input  logic [4:0]           rs1_addr,
   input  logic [4:0]           rs2_addr,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   output logic [31:0]          busy_vec
);

   import regfile_pkg::*;

   logic [NREQ-1:0]   w_gnt;
   logic              w_hs;
   logic [4:0]        w_addr;
   logic [XLEN-1:0]   w_data;
   logic [NREGS-1:0]  w_set;
   logic [NREGS-1:0]  w_clr;

   logic              r_wen;
   logic [4:0]        r_waddr;
   logic [XLEN-1:0]   r_wdata;
   logic [NREGS-1:0]  r_busy;

   rr_arbiter #(
      .NREQ    (NREQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (w_hs),
      .gnt     (w_gnt)
   );

   assign req_ready = w_gnt;
   assign w_hs      = |w_gnt;

   // Select the granted requester's address and data (grant is one-hot).
   always_comb begin
      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_addr = w_addr | req_addr[5*i +: 5];
            w_data = w_data | req_data[XLEN*i +: XLEN];
         end
      end
   end

   // Registered write towards the regfile; x0 writes are absorbed here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= w_hs && (w_addr != '0);
         if (w_hs) begin
            r_waddr <= w_addr;
            r_wdata <= w_data;
         end
      end
   end

   // Scoreboard set/clear masks; a set of the same register overrides a clear.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (sb_set && (sb_set_addr != '0)) w_set = reg_onehot(sb_set_addr);
      if (r_wen) w_clr = reg_onehot(r_waddr);
   end

   // Busy scoreboard; x0 can never be marked busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREGS'(1);
      end
   end

   assign rf_wen   = r_wen;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;
   assign busy_vec = r_busy;
   assign rs1_busy = (rs1_addr != '0) && r_busy[rs1_addr];
   assign rs2_busy = (rs2_addr != '0) && r_busy[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter: cycle table plus reset sequences.
// Inputs change on negedge, outputs are sampled 1ns later.
module tb_regfile_wb_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    req_valid;
   logic [14:0]   req_addr;
   logic [191:0]  req_data;
   logic [2:0]    req_ready;
   logic          rf_wen;
   logic [4:0]    rf_waddr;
   logic [63:0]   rf_wdata;
   logic          sb_set;
   logic [4:0]    sb_set_addr;
   logic [4:0]    rs1_addr;
   logic [4:0]    rs2_addr;
   logic          rs1_busy;
   logic          rs2_busy;
   logic [31:0]   busy_vec;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .sb_set      (sb_set),
      .sb_set_addr (sb_set_addr),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .busy_vec    (busy_vec)
   );

   typedef struct {
      logic [2:0]  v;
      logic [4:0]  a0, a1, a2;
      logic [63:0] d0, d1, d2;
      logic        sb;
      logic [4:0]  sba, r1, r2;
      logic [2:0]  rdy;
      logic        wen;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic [31:0] busy;
      logic        b1, b2;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic void add(
      input logic [2:0] v, input logic [4:0] a0, a1, a2,
      input logic [63:0] d0, d1, d2,
      input logic sb, input logic [4:0] sba, r1, r2,
      input logic [2:0] rdy, input logic wen, input logic [4:0] wa,
      input logic [63:0] wd, input logic [31:0] busy,
      input logic b1, b2);
      vec_t t;
      t = '{v, a0, a1, a2, d0, d1, d2, sb, sba, r1, r2,
            rdy, wen, wa, wd, busy, b1, b2};
      tbl.push_back(t);
   endfunction

   task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                        input logic [63:0] d0, d1, d2);
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
   endtask

   localparam logic [63:0] DB = 64'hDEAD_BEEF;

   initial begin
      rst = 1'b1;
      sb_set = 1'b0;
      sb_set_addr = '0;
      rs1_addr = '0;
      rs2_addr = '0;
      drive(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33);

      // v  a0 a1 a2  d0 d1 d2  sb sba r1 r2 | rdy wen wa wd busy b1 b2
      add(3'b001, 5, 0, 0, DB, 0, 0, 0, 0, 0, 0,
          3'b001, 0, 0, 0, 0, 0, 0);
      add(3'b010, 0, 0, 0, 0, 64'h55, 0, 0, 0, 0, 0,
          3'b010, 1, 5, DB, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
          3'b000, 0, 0, 64'h55, 0, 0, 0);
      add(3'b110, 0, 2, 3, 0, 64'h22, 64'h33, 0, 0, 0, 0,
          3'b100, 0, 0, 64'h55, 0, 0, 0);
      add(3'b111, 1, 2, 3, 64'h11, 64'h22, 64'h33, 0, 0, 0, 0,
          3'b001, 1, 3, 64'h33, 0, 0, 0);
      add(3'b111, 1, 2, 3, 64'h11, 64'h22, 64'h33, 0, 0, 0, 0,
          3'b010, 1, 1, 64'h11, 0, 0, 0);
      add(3'b111, 1, 2, 3, 64'h11, 64'h22, 64'h33, 0, 0, 0, 0,
          3'b100, 1, 2, 64'h22, 0, 0, 0);
      add(3'b111, 1, 2, 3, 64'h11, 64'h22, 64'h33, 0, 0, 0, 0,
          3'b001, 1, 3, 64'h33, 0, 0, 0);
      add(3'b111, 1, 2, 3, 64'h11, 64'h22, 64'h33, 0, 0, 0, 0,
          3'b010, 1, 1, 64'h11, 0, 0, 0);
      add(3'b111, 1, 2, 3, 64'h11, 64'h22, 64'h33, 0, 0, 0, 0,
          3'b100, 1, 2, 64'h22, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
          3'b000, 1, 3, 64'h33, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0,
          3'b000, 0, 3, 64'h33, 0, 0, 0);
      add(3'b100, 0, 0, 7, 0, 0, 64'h77, 0, 0, 7, 0,
          3'b100, 0, 3, 64'h33, 32'h80, 1, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0,
          3'b000, 1, 7, 64'h77, 32'h80, 1, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0,
          3'b000, 0, 7, 64'h77, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0,
          3'b000, 0, 7, 64'h77, 0, 0, 0);
      add(3'b001, 9, 0, 0, 64'h99, 0, 0, 0, 0, 9, 0,
          3'b001, 0, 7, 64'h77, 32'h200, 1, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0,
          3'b000, 1, 9, 64'h99, 32'h200, 1, 0);
      add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0,
          3'b000, 0, 9, 64'h99, 32'h200, 1, 0);
      add(3'b010, 0, 9, 0, 0, 64'h9A, 0, 0, 0, 0, 9,
          3'b010, 0, 9, 64'h99, 32'h200, 0, 1);
      add(3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 0, 9,
          3'b000, 1, 9, 64'h9A, 32'h200, 0, 1);
      add(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 4, 9,
          3'b000, 0, 9, 64'h9A, 32'h10, 1, 0);

      // Reset holds grants low even with every source valid.
      @(negedge clk);
      #1;
      chk("rst_ready", 64'(req_ready), 64'(3'b000));
      @(negedge clk);
      rst = 1'b0;
      drive(3'b000, 0, 0, 0, 0, 0, 0);
      #1;
      chk("post_rst_wen", 64'(rf_wen), 0);
      chk("post_rst_busy", 64'(busy_vec), 0);

      foreach (tbl[n]) begin
         vec_t t;
         t = tbl[n];
         if (n != 0) @(negedge clk);
         drive(t.v, t.a0, t.a1, t.a2, t.d0, t.d1, t.d2);
         sb_set      = t.sb;
         sb_set_addr = t.sba;
         rs1_addr    = t.r1;
         rs2_addr    = t.r2;
         #1;
         chk($sformatf("v%0d_ready", n), 64'(req_ready), 64'(t.rdy));
         chk($sformatf("v%0d_wen", n), 64'(rf_wen), 64'(t.wen));
         chk($sformatf("v%0d_waddr", n), 64'(rf_waddr), 64'(t.wa));
         chk($sformatf("v%0d_wdata", n), rf_wdata, t.wd);
         chk($sformatf("v%0d_busy", n), 64'(busy_vec), 64'(t.busy));
         chk($sformatf("v%0d_rs1b", n), 64'(rs1_busy), 64'(t.b1));
         chk($sformatf("v%0d_rs2b", n), 64'(rs2_busy), 64'(t.b2));
      end

      // Mid-operation reset: in-flight write and busy bits are dropped.
      // Pointer is 2 here (last grant was LSU), so MDU wins.
      @(negedge clk);
      drive(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33);
      sb_set      = 1'b1;
      sb_set_addr = 5'd6;
      rs1_addr    = 5'd0;
      rs2_addr    = 5'd0;
      #1;
      chk("mid_ready", 64'(req_ready), 64'(3'b100));
      @(negedge clk);
      sb_set = 1'b0;
      rst    = 1'b1;
      #1;
      chk("mid_inflight_wen", 64'(rf_wen), 1);
      chk("mid_busy_set", 64'(busy_vec), 64'(32'h50));
      chk("mid_rst_ready", 64'(req_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_post_wen", 64'(rf_wen), 0);
      chk("mid_post_waddr", 64'(rf_waddr), 0);
      chk("mid_post_wdata", rf_wdata, 0);
      chk("mid_post_busy", 64'(busy_vec), 0);
      chk("mid_post_ptr0", 64'(req_ready), 64'(3'b001));

      @(negedge clk);
      drive(3'b000, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
